// File: rtl/rat_recovery_seq.sv
// rat_recovery_seq: recovery sequencer for the rename stage.
// On a flush it snapshots the committed RAT, replays it into the front RAT
// one entry per cycle, rebuilds the physical free mask from the same
// snapshot, and holds rename stalled until the sequence is over.
module rat_recovery_seq #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6,
  parameter int PHY_REGS  = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_req,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat,
  output logic                           rename_stall,
  output logic                           frat_we,
  output logic [$clog2(ARCH_REGS)-1:0]   frat_waddr,
  output logic [PHY_WIDTH-1:0]           frat_wdata,
  output logic                           free_mask_valid,
  output logic [PHY_REGS-1:0]            free_mask,
  output logic                           recovery_done,
  output logic                           map_err
);

  localparam int IDX_W = $clog2(ARCH_REGS);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    REBUILD,
    DONE
  } state_t;

  state_t                         state;
  logic [IDX_W-1:0]               idx;
  logic [PHY_WIDTH*ARCH_REGS-1:0] snapshot;
  logic [PHY_REGS-1:0]            used_mask;
  logic [PHY_REGS-1:0]            free_mask_q;
  logic                           map_err_q;

  logic [PHY_WIDTH-1:0]           cur_phys;
  logic                           cur_in_range;
  logic [PHY_REGS-1:0]            cur_bit;
  logic                           cur_dup;
  logic                           last_entry;

  // Entry being copied this cycle, and whether it is a legal, unused phys reg.
  // An out-of-range entry contributes no mask bit so it cannot corrupt the free list.
  assign cur_phys     = snapshot[int'(idx)*PHY_WIDTH +: PHY_WIDTH];
  assign cur_in_range = ({{(32-PHY_WIDTH){1'b0}}, cur_phys} < 32'(PHY_REGS));
  assign cur_bit      = cur_in_range ? (PHY_REGS'(1) << cur_phys) : '0;
  assign cur_dup      = |(used_mask & cur_bit);
  assign last_entry   = (idx == IDX_W'(ARCH_REGS - 1));

  // Outputs decode from the registered state; the stall also covers the flush
  // cycle itself so no rename slips through before the FSM leaves IDLE.
  assign rename_stall    = flush_req | (state != IDLE);
  assign frat_we         = (state == COPY);
  assign frat_waddr      = (state == COPY) ? idx : '0;
  assign frat_wdata      = (state == COPY) ? cur_phys : '0;
  assign free_mask_valid = (state == REBUILD);
  assign free_mask       = free_mask_q;
  assign recovery_done   = (state == DONE);
  assign map_err         = map_err_q;

  // Recovery FSM: a flush in any state (re)starts from a fresh snapshot; the
  // final free mask is latched on the last copy so it already includes that entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      snapshot    <= '0;
      used_mask   <= '0;
      free_mask_q <= '0;
      map_err_q   <= 1'b0;
    end else if (flush_req) begin
      state     <= COPY;
      idx       <= '0;
      snapshot  <= back_rat;
      used_mask <= '0;
      map_err_q <= 1'b0;
    end else begin
      case (state)
        COPY: begin
          used_mask <= used_mask | cur_bit;
          if (!cur_in_range || cur_dup) begin
            map_err_q <= 1'b1;
          end
          if (last_entry) begin
            free_mask_q <= ~(used_mask | cur_bit);
            state       <= REBUILD;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        REBUILD: state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
